// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM generator: handshake states, period limit
// and the default reset ratio.
package pwm_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PENDING = 2'd1,
    DONE    = 2'd2
  } hs_state_t;

  localparam logic [7:0] PWM_PERIOD_MAX      = 8'd254;
  localparam logic [7:0] DEFAULT_RESET_RATIO = 8'd128;

endpackage

// File: rtl/pwm_prescaler.sv
// Divides the clock by CLK_DIV to produce the PWM count tick; the divider
// is held at zero whenever it is not enabled.
module pwm_prescaler #(
  parameter int CLK_DIV = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic enable,
  output logic tick
);

  localparam int W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [W-1:0] LAST = W'(CLK_DIV - 1);

  logic [W-1:0] pre;

  assign tick = enable && (pre == LAST);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pre <= '0;
    end else if (!enable || pre == LAST) begin
      pre <= '0;
    end else begin
      pre <= pre + 1'b1;
    end
  end

endmodule

// File: rtl/pwm_generator.sv
// PWM generator with a double-buffered ratio that is accepted through a
// level update/done handshake and applied only on a period boundary.
module pwm_generator
  import pwm_pkg::*;
#(
  parameter int         CLK_DIV     = 4,
  parameter logic [7:0] RESET_RATIO = DEFAULT_RESET_RATIO
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       pwm_enable,
  input  logic       pwm_update,
  input  logic [7:0] pwm_ratio,
  output logic       pwm_done,
  output logic       pwm_out,
  output logic       period_start,
  output logic [7:0] active_ratio
);

  hs_state_t  state;
  logic [7:0] shadow;
  logic [7:0] count;
  logic       running;
  logic       pre_enable;
  logic       tick;
  logic       wrap;
  logic       apply;
  logic [7:0] count_next;
  logic [7:0] active_next;

  // The prescaler only starts once the first enabled clock has parked the
  // count at zero, so every period begins with a full count-0 slot.
  assign pre_enable = pwm_enable && running;

  pwm_prescaler #(
    .CLK_DIV(CLK_DIV)
  ) u_prescaler (
    .clock (clock),
    .reset (reset),
    .enable(pre_enable),
    .tick  (tick)
  );

  assign wrap  = tick && (count == PWM_PERIOD_MAX);
  assign apply = (state == PENDING) && pwm_update && (wrap || !pwm_enable);

  always_comb begin
    count_next  = count;
    active_next = apply ? shadow : active_ratio;
    if (!pwm_enable || !running) begin
      count_next = 8'd0;
    end else if (tick) begin
      count_next = (count == PWM_PERIOD_MAX) ? 8'd0 : count + 8'd1;
    end
  end

  // Outputs are registered from the next-state values so that a newly
  // applied ratio and period_start line up with the first clock at count 0.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      shadow       <= RESET_RATIO;
      active_ratio <= RESET_RATIO;
      count        <= 8'd0;
      running      <= 1'b0;
      pwm_out      <= 1'b0;
      period_start <= 1'b0;
      pwm_done     <= 1'b0;
    end else begin
      running      <= pwm_enable;
      count        <= count_next;
      active_ratio <= active_next;
      pwm_out      <= pwm_enable && (count_next < active_next);
      period_start <= pwm_enable && (wrap || !running);
      case (state)
        IDLE: begin
          if (pwm_update) begin
            shadow <= pwm_ratio;
            state  <= PENDING;
          end
        end
        PENDING: begin
          if (!pwm_update) begin
            state <= IDLE;
          end else begin
            shadow <= pwm_ratio;
            if (apply) begin
              pwm_done <= 1'b1;
              state    <= DONE;
            end
          end
        end
        DONE: begin
          if (!pwm_update) begin
            pwm_done <= 1'b0;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pwm_generator.sv
// Self-checking bench for pwm_generator: a period/phase reference model checked
// every cycle, plus directed scenarios with hand-computed expectations.
module tb_pwm_generator;

  localparam int         CLK_DIV = 1;
  localparam int         PERIOD  = 255 * CLK_DIV;
  localparam logic [7:0] RST_RAT = 8'd128;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       pwm_enable = 1'b0;
  logic       pwm_update = 1'b0;
  logic [7:0] pwm_ratio = 8'd0;
  logic       pwm_done;
  logic       pwm_out;
  logic       period_start;
  logic [7:0] active_ratio;

  int tests = 0;
  int fails = 0;
  logic check_en = 1'b0;

  pwm_generator #(
    .CLK_DIV    (CLK_DIV),
    .RESET_RATIO(RST_RAT)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .pwm_enable  (pwm_enable),
    .pwm_update  (pwm_update),
    .pwm_ratio   (pwm_ratio),
    .pwm_done    (pwm_done),
    .pwm_out     (pwm_out),
    .period_start(period_start),
    .active_ratio(active_ratio)
  );

  always #5 clock = ~clock;

  // Reference model: position within the period measured in clocks, with the
  // handshake described as "waiting for a boundary" / "done" flags.
  int   m_phase;
  int   m_active;
  int   m_shadow;
  logic m_running;
  logic m_waiting;
  logic m_done;
  logic m_out;
  logic m_ps;

  always @(posedge clock or posedge reset) begin
    int   ph;
    int   act;
    int   shd;
    logic wt;
    logic dn;
    logic boundary;
    if (reset) begin
      m_phase   <= 0;
      m_active  <= RST_RAT;
      m_shadow  <= RST_RAT;
      m_running <= 1'b0;
      m_waiting <= 1'b0;
      m_done    <= 1'b0;
      m_out     <= 1'b0;
      m_ps      <= 1'b0;
    end else begin
      boundary = m_running && pwm_enable && (m_phase == PERIOD - 1);
      ph  = (!pwm_enable || !m_running) ? 0 : (m_phase + 1) % PERIOD;
      act = m_active;
      shd = m_shadow;
      wt  = m_waiting;
      dn  = m_done;
      if (dn) begin
        if (!pwm_update) dn = 1'b0;
      end else if (wt) begin
        if (!pwm_update) begin
          wt = 1'b0;
        end else begin
          if (boundary || !pwm_enable) begin
            act = shd;
            dn  = 1'b1;
            wt  = 1'b0;
          end
          shd = pwm_ratio;
        end
      end else if (pwm_update) begin
        shd = pwm_ratio;
        wt  = 1'b1;
      end
      m_phase   <= ph;
      m_active  <= act;
      m_shadow  <= shd;
      m_waiting <= wt;
      m_done    <= dn;
      m_running <= pwm_enable;
      m_out     <= pwm_enable && (ph < act * CLK_DIV);
      m_ps      <= pwm_enable && (ph == 0);
    end
  end

  task automatic check_output(input string name, input int actual, input int expected);
    tests++;
    if (actual != expected) begin
      fails++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  always @(negedge clock) begin
    if (check_en && !reset) begin
      check_output("model_pwm_out", int'(pwm_out), int'(m_out));
      check_output("model_period_start", int'(period_start), int'(m_ps));
      check_output("model_pwm_done", int'(pwm_done), int'(m_done));
      check_output("model_active_ratio", int'(active_ratio), m_active);
    end
  end

  task automatic apply_stimulus(input logic upd, input logic [7:0] ratio);
    pwm_update = upd;
    pwm_ratio  = ratio;
  endtask

  task automatic wait_period_start();
    int n = 0;
    while (!period_start && n < 600) begin
      @(negedge clock);
      n++;
    end
    check_output("period_start_seen", int'(period_start), 1);
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    do begin
      @(negedge clock);
      lat++;
    end while (!pwm_done && lat < 600);
    check_output("done_seen", int'(pwm_done), 1);
  endtask

  task automatic measure(output int highs, output int starts);
    highs  = 0;
    starts = 0;
    for (int i = 0; i < PERIOD; i++) begin
      if (pwm_out) highs++;
      if (period_start) starts++;
      @(negedge clock);
    end
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation still running, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int   lat;
    int   highs;
    int   starts;
    logic done_seen;

    // Reset and default ratio
    #1 reset = 1'b1;
    repeat (3) @(negedge clock);
    check_en = 1'b1;
    check_output("reset_active_ratio", int'(active_ratio), 128);
    check_output("reset_pwm_out", int'(pwm_out), 0);
    check_output("reset_pwm_done", int'(pwm_done), 0);
    check_output("reset_period_start", int'(period_start), 0);
    reset = 1'b0;
    pwm_enable = 1'b1;
    wait_period_start();
    measure(highs, starts);
    check_output("default_highs", highs, 128);
    check_output("default_starts", starts, 1);

    // Basic apply requested at count 10
    wait_period_start();
    repeat (10) @(negedge clock);
    apply_stimulus(1'b1, 8'd200);
    wait_done(lat);
    check_output("apply_latency", lat, 245);
    check_output("apply_period_start", int'(period_start), 1);
    check_output("apply_active_ratio", int'(active_ratio), 200);
    measure(highs, starts);
    check_output("ratio200_highs", highs, 200);
    apply_stimulus(1'b0, 8'd200);
    @(negedge clock);
    check_output("done_falls", int'(pwm_done), 0);

    // Ratio stepped while pending: only the last value lands
    repeat (4) @(negedge clock);
    apply_stimulus(1'b1, 8'd50);
    repeat (3) @(negedge clock);
    apply_stimulus(1'b1, 8'd60);
    repeat (3) @(negedge clock);
    apply_stimulus(1'b1, 8'd70);
    wait_done(lat);
    check_output("latest_wins_ratio", int'(active_ratio), 70);
    measure(highs, starts);
    check_output("ratio70_highs", highs, 70);
    apply_stimulus(1'b0, 8'd70);
    repeat (2) @(negedge clock);

    // Edge ratios 0 and 255
    apply_stimulus(1'b1, 8'd0);
    wait_done(lat);
    apply_stimulus(1'b0, 8'd0);
    measure(highs, starts);
    check_output("ratio0_highs", highs, 0);
    check_output("ratio0_starts", starts, 1);
    apply_stimulus(1'b1, 8'd255);
    wait_done(lat);
    apply_stimulus(1'b0, 8'd255);
    measure(highs, starts);
    check_output("ratio255_highs", highs, 255);
    check_output("ratio255_starts", starts, 1);
    measure(highs, starts);
    check_output("ratio255_starts_again", starts, 1);

    // Request sampled on the wrap edge waits a full period
    wait_period_start();
    repeat (254) @(negedge clock);
    apply_stimulus(1'b1, 8'd77);
    wait_done(lat);
    check_output("coincident_latency", lat, 256);
    apply_stimulus(1'b0, 8'd77);

    // Abort while pending
    repeat (5) @(negedge clock);
    apply_stimulus(1'b1, 8'd99);
    repeat (20) @(negedge clock);
    apply_stimulus(1'b0, 8'd99);
    done_seen = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clock);
      done_seen = done_seen | pwm_done;
    end
    check_output("abort_no_done", int'(done_seen), 0);
    check_output("abort_active_ratio", int'(active_ratio), 77);

    // Enable low: handshake still completes, output stays low
    pwm_enable = 1'b0;
    repeat (3) @(negedge clock);
    check_output("disabled_pwm_out", int'(pwm_out), 0);
    apply_stimulus(1'b1, 8'd30);
    wait_done(lat);
    check_output("disabled_latency", lat, 2);
    check_output("disabled_out_low", int'(pwm_out), 0);
    apply_stimulus(1'b0, 8'd30);
    repeat (2) @(negedge clock);
    pwm_enable = 1'b1;
    @(negedge clock);
    check_output("enable_start_ps", int'(period_start), 1);
    measure(highs, starts);
    check_output("ratio30_highs", highs, 30);
    check_output("ratio30_starts", starts, 1);

    // Asynchronous reset with a request pending and output high
    apply_stimulus(1'b1, 8'd180);
    repeat (3) @(negedge clock);
    @(posedge clock);
    #2 reset = 1'b1;
    #1;
    check_output("async_reset_out", int'(pwm_out), 0);
    check_output("async_reset_done", int'(pwm_done), 0);
    check_output("async_reset_ratio", int'(active_ratio), 128);
    @(negedge clock);
    apply_stimulus(1'b0, 8'd180);
    reset = 1'b0;
    wait_period_start();
    measure(highs, starts);
    check_output("post_reset_highs", highs, 128);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
